// File: rtl/block_ram_port_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// block_ram_port_master
// Valid/ready front-end for one block-RAM port with a 2-entry read-response
// buffer and a built-in constant fill engine.
// Revision: 1.0
//------------------------------------------------------------------------------
module block_ram_port_master #(
  parameter int DATA_BYTES  = 2,
  parameter int PARITY_BITS = 0,
  parameter int ADDR_WIDTH  = 10,
  localparam int DATA_WIDTH = DATA_BYTES * (8 + PARITY_BITS),
  parameter logic [DATA_WIDTH-1:0] FILL_VAL = '0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [DATA_BYTES-1:0] reqByteEnable,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [DATA_WIDTH-1:0] reqData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspData,
  input  logic                  fillStart,
  output logic                  fillBusy,
  output logic                  fillDone,
  output logic                  ramEnable,
  output logic [DATA_BYTES-1:0] ramWriteEnable,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramDataIn,
  input  logic [DATA_WIDTH-1:0] ramDataOut
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_fill = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_addr_last = {ADDR_WIDTH{1'b1}};

  logic [1:0]            r_state;
  logic                  r_inflight;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [ADDR_WIDTH-1:0] r_fill_addr;

  logic w_idle;
  logic w_credit;
  logic w_accept;
  logic w_push;
  logic w_pop;

  // A read costs a buffer slot from acceptance on, so the buffer can never overflow.
  assign w_idle   = (r_state == c_st_idle);
  assign w_credit = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
  assign reqReady = resetN & w_idle & ~fillStart & w_credit;
  assign w_accept = reqValid & reqReady;

  assign rspValid = (r_count != 2'd0);
  assign rspData  = r_head;
  assign w_pop    = rspValid & rspReady;
  assign w_push   = r_inflight;

  assign fillBusy = (r_state != c_st_idle);
  assign fillDone = (r_state == c_st_done);

  always_comb begin
    ramEnable      = 1'b0;
    ramWriteEnable = '0;
    ramAddress     = '0;
    ramDataIn      = '0;
    if (resetN) begin
      case (r_state)
        c_st_idle: begin
          ramEnable      = w_accept;
          ramWriteEnable = (w_accept & reqWrite) ? reqByteEnable : '0;
          ramAddress     = reqAddress;
          ramDataIn      = reqData;
        end
        c_st_fill: begin
          ramEnable      = 1'b1;
          ramWriteEnable = {DATA_BYTES{1'b1}};
          ramAddress     = r_fill_addr;
          ramDataIn      = FILL_VAL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= c_st_idle;
      r_fill_addr <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (fillStart) r_state <= c_st_fill;
        end
        c_st_fill: begin
          r_fill_addr <= r_fill_addr + c_addr_one;
          if (r_fill_addr == c_addr_last) r_state <= c_st_done;
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  // r_head is the visible output word; it keeps its value once the buffer drains.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_accept & ~reqWrite;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= ramDataOut;
          else                 r_tail <= ramDataOut;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= ramDataOut;
          end else begin
            r_head <= r_tail;
            r_tail <= ramDataOut;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_ram_port_master.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_block_ram_port_master
// Directed table, corner sequences and random traffic against a word-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_block_ram_port_master;
  localparam int AW    = 4;
  localparam int DB    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] FV = 16'hA5A5;

  logic          clock = 1'b0;
  logic          resetN = 1'b1;
  logic          reqValid, reqReady, reqWrite;
  logic [DB-1:0] reqByteEnable;
  logic [AW-1:0] reqAddress;
  logic [DW-1:0] reqData;
  logic          rspValid, rspReady;
  logic [DW-1:0] rspData;
  logic          fillStart, fillBusy, fillDone;
  logic          ramEnable;
  logic [DB-1:0] ramWriteEnable;
  logic [AW-1:0] ramAddress;
  logic [DW-1:0] ramDataIn, ramDataOut;

  always #5 clock = ~clock;

  block_ram_port_master #(
    .DATA_BYTES(DB), .PARITY_BITS(0), .ADDR_WIDTH(AW), .FILL_VAL(FV)
  ) dut (
    .clock(clock), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqByteEnable(reqByteEnable), .reqAddress(reqAddress), .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .fillStart(fillStart), .fillBusy(fillBusy), .fillDone(fillDone),
    .ramEnable(ramEnable), .ramWriteEnable(ramWriteEnable),
    .ramAddress(ramAddress), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  // Read-first byte-lane RAM attached to the port.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_init = 1'b0;
  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      ram_init <= 1'b1;
    end else if (ramEnable) begin
      ramDataOut <= ram[ramAddress];
      for (int b = 0; b < DB; b++)
        if (ramWriteEnable[b]) ram[ramAddress][b*8 +: 8] <= ramDataIn[b*8 +: 8];
    end
  end

  // Word-level model: expected memory contents and expected response order.
  logic [DW-1:0] gold [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rsp;
  logic          s_rr, s_rv, s_fb, s_fd, s_re, s_acc;
  logic [DB-1:0] s_we;
  logic [AW-1:0] s_ra;
  int            total = 0;
  int            bad = 0;

  typedef struct {
    logic          wr;
    logic [DB-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One clock: sample mid-cycle, score the handshakes, return just after the edge.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clock);
    s_rr = reqReady; s_rv = rspValid; s_fb = fillBusy; s_fd = fillDone;
    s_re = ramEnable; s_we = ramWriteEnable; s_ra = ramAddress;
    s_acc = reqValid & reqReady;
    if (rspValid && rspReady) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got data %0h required no response", rspData);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", rspData, e);
        last_rsp = rspData;
      end
    end
    if (s_acc) begin
      if (reqWrite) begin
        for (int b = 0; b < DB; b++)
          if (reqByteEnable[b]) gold[reqAddress][b*8 +: 8] = reqData[b*8 +: 8];
      end else begin
        exp_q.push_back(gold[reqAddress]);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic do_req(input logic wr, input logic [DB-1:0] be,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    reqValid = 1'b1; reqWrite = wr; reqByteEnable = be; reqAddress = a; reqData = d;
    do begin tick(); n++; end while (!s_acc && n < 50);
    check("req_accept", s_acc, 1);
    reqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rspReady = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    check("drain_empty", exp_q.size(), 0);
    tick();
    check("no_extra_rsp", s_rv, 0);
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] req);
    do_req(1'b0, '0, a, '0);
    drain();
    check(name, last_rsp, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int dones;
    vecs[0] = '{1'b1, 2'b10, 4'd3, 16'h1234, 16'h0000};
    vecs[1] = '{1'b0, 2'b00, 4'd3, 16'h0000, 16'h12EF};
    vecs[2] = '{1'b1, 2'b11, 4'd1, 16'h0001, 16'h0000};
    vecs[3] = '{1'b1, 2'b11, 4'd2, 16'h0002, 16'h0000};
    vecs[4] = '{1'b1, 2'b11, 4'd3, 16'h0003, 16'h0000};
    vecs[5] = '{1'b1, 2'b01, 4'd5, 16'h77CD, 16'h0000};
    vecs[6] = '{1'b0, 2'b00, 4'd5, 16'h0000, 16'h00CD};
    vecs[7] = '{1'b0, 2'b00, 4'd1, 16'h0000, 16'h0001};
    vecs[8] = '{1'b0, 2'b00, 4'd3, 16'h0000, 16'h0003};

    for (int i = 0; i < DEPTH; i++) gold[i] = '0;
    last_rsp = '0;
    reqValid = 1'b1; reqWrite = 1'b0; reqByteEnable = '0; reqAddress = '0; reqData = '0;
    rspReady = 1'b0; fillStart = 1'b0;

    // Reset state, with a request pending to show reqReady is gated.
    #1 resetN = 1'b0;
    #1;
    check("rst_reqReady", reqReady, 0);
    check("rst_ramEnable", ramEnable, 0);
    check("rst_rspValid", rspValid, 0);
    check("rst_rspData", rspData, 0);
    check("rst_fillBusy", fillBusy, 0);
    check("rst_fillDone", fillDone, 0);
    reqValid = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;

    // Write then read with latency checks.
    rspReady = 1'b1;
    do_req(1'b1, 2'b11, 4'd3, 16'hBEEF);
    do_req(1'b0, 2'b00, 4'd3, 16'h0000);
    tick(); check("lat_cycle1_rspValid", s_rv, 0);
    tick(); check("lat_cycle2_rspValid", s_rv, 1);
    check("lat_rspData", last_rsp, 16'hBEEF);
    tick(); check("single_rsp", s_rv, 0);
    check("single_rsp_queue", exp_q.size(), 0);

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].data);
      if (!vecs[i].wr) begin
        drain();
        check($sformatf("vec%0d_rdata", i), last_rsp, vecs[i].exp);
      end
    end

    // Backpressure: two reads fill the credits, the third waits for a pop.
    rspReady = 1'b0;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 4'd1;
    tick(); check("bb_acc1", s_acc, 1);
    reqAddress = 4'd2;
    tick(); check("bb_acc2", s_acc, 1);
    reqAddress = 4'd3;
    tick(); check("bb_stall1", s_rr, 0);
    tick(); check("bb_stall2", s_rr, 0);
    rspReady = 1'b1;
    tick(); check("bb_stall_at_pop", s_rr, 0);
    tick(); check("bb_acc3", s_acc, 1);
    reqValid = 1'b0;
    drain();
    check("bb_last", last_rsp, 16'h0003);

    // Full fill.
    fillStart = 1'b1;
    tick(); check("fill_start_rr", s_rr, 0);
    fillStart = 1'b0;
    for (int i = 0; i < DEPTH; i++) gold[i] = FV;
    for (int i = 0; i <= DEPTH; i++) begin
      tick();
      check("fill_busy", s_fb, 1);
      check("fill_done", s_fd, (i == DEPTH) ? 1 : 0);
      check("fill_rr", s_rr, 0);
      if (i < DEPTH) begin
        check("fill_en", s_re, 1);
        check("fill_we", s_we, 2'b11);
        check("fill_addr", s_ra, i);
      end
    end
    tick(); check("fill_idle", s_fb, 0);
    read_check("fill_rd0", 4'd0, FV);
    read_check("fill_rd15", 4'd15, FV);

    // Reset while filling address 7.
    do_req(1'b1, 2'b11, 4'd10, 16'h5555);
    do_req(1'b1, 2'b11, 4'd6, 16'h6666);
    do_req(1'b1, 2'b11, 4'd8, 16'h8888);
    fillStart = 1'b1;
    tick();
    fillStart = 1'b0;
    repeat (7) tick();
    check("abort_addr", ramAddress, 7);
    resetN = 1'b0;
    #1;
    check("abort_ramEnable", ramEnable, 0);
    check("abort_ramWe", ramWriteEnable, 0);
    check("abort_ramAddr", ramAddress, 0);
    check("abort_fillBusy", fillBusy, 0);
    check("abort_fillDone", fillDone, 0);
    check("abort_rspData", rspData, 0);
    check("abort_rspValid", rspValid, 0);
    exp_q.delete();
    for (int i = 0; i < 7; i++) gold[i] = FV;
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_fd) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_idle", s_fb, 0);
    read_check("abort_rd10", 4'd10, 16'h5555);
    read_check("abort_rd6", 4'd6, FV);
    read_check("abort_rd8", 4'd8, 16'h8888);

    // fillStart beats a same-cycle request.
    reqValid = 1'b1; reqWrite = 1'b1; reqByteEnable = 2'b11; reqAddress = 4'd2; reqData = 16'h1111;
    fillStart = 1'b1;
    for (int i = 0; i < DEPTH; i++) gold[i] = FV;
    tick(); check("prio_noacc", s_acc, 0);
    fillStart = 1'b0;
    n = 0; dones = 0;
    do begin
      tick(); n++;
      if (s_fd) dones++;
    end while (!s_acc && n < 40);
    check("prio_acc_cycle", n, DEPTH + 2);
    check("prio_done_seen", dones, 1);
    reqValid = 1'b0;
    read_check("prio_rd2", 4'd2, 16'h1111);

    // Random traffic scored by the model.
    for (int i = 0; i < 400; i++) begin
      reqValid      = ($urandom_range(0, 3) != 0);
      reqWrite      = ($urandom_range(0, 2) == 0);
      reqByteEnable = DB'($urandom_range(0, 3));
      reqAddress    = AW'($urandom_range(0, DEPTH - 1));
      reqData       = DW'($urandom);
      rspReady      = ($urandom_range(0, 1) == 1);
      tick();
    end
    reqValid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/block_ram_port_master.md
Name: block_ram_port_master

Overview:
Request/response front-end that owns one read/write port of the team's dual-port byte-lane block RAM. It accepts valid/ready read and write requests and drives the RAM port signals. It returns read data on a valid/ready response stream through a 2-entry buffer, so backpressure never loses data. A built-in fill engine writes a constant to every RAM word on command, which is used for clear-on-boot without an init file.

Parameters:
DATA_BYTES, 2, number of byte columns per word.
PARITY_BITS, 0, extra bits per column; column width = 8+PARITY_BITS; DATA_WIDTH = DATA_BYTES*(8+PARITY_BITS).
ADDR_WIDTH, 10, RAM address width; depth = 2^ADDR_WIDTH.
FILL_VAL, all zeros (DATA_WIDTH bits), word written by the fill engine.

Ports:
clock  in  1  single clock; the RAM port uses the same clock.
resetN  in  1  asynchronous, active-low reset.
reqValid  in  1  request valid.
reqReady  out  1  request accepted when reqValid&reqReady at the rising edge.
reqWrite  in  1  1=write, 0=read.
reqByteEnable  in  DATA_BYTES  per-column write enable; ignored on reads.
reqAddress  in  ADDR_WIDTH  word address.
reqData  in  DATA_WIDTH  write data.
rspValid  out  1  read data available.
rspReady  in  1  response consumed when rspValid&rspReady.
rspData  out  DATA_WIDTH  read data, head of buffer.
fillStart  in  1  single-cycle pulse; starts the fill.
fillBusy  out  1  fill in progress.
fillDone  out  1  one-cycle pulse on fill completion.
ramEnable  out  1  RAM port enable.
ramWriteEnable  out  DATA_BYTES  RAM per-column write enable.
ramAddress  out  ADDR_WIDTH  RAM address.
ramDataIn  out  DATA_WIDTH  RAM write data.
ramDataOut  in  DATA_WIDTH  RAM registered read data: read-first, updates only on the edge where ramEnable=1.

Behaviour:
- Reset (resetN low, asynchronous):
  - State=IDLE; response buffer emptied; in-flight flag cleared; fill counter=0.
  - rspValid=0, rspData=0, fillBusy=0, fillDone=0.
  - reqReady and all ram* outputs are forced to 0 while resetN is low.
- States:
  - IDLE: serves requests.
  - FILL: writes one word per cycle.
  - DONE: a single cycle that pulses fillDone, then returns to IDLE.
- reqReady = resetN & (state==IDLE) & !fillStart & (count + inflight < 2).
  - count = buffered responses (0..2); inflight = read accepted on the previous edge.
  - Writes use the same credit rule for simplicity.
- RAM drive in IDLE is combinational from the request:
  - ramEnable = reqValid&reqReady.
  - ramWriteEnable = reqWrite ? reqByteEnable : 0, gated by ramEnable.
  - ramAddress = reqAddress; ramDataIn = reqData.
- Read latency:
  - The read is accepted at edge N; ramDataOut is valid after edge N.
  - The buffer captures ramDataOut at edge N+1; rspValid is high after edge N+1.
  - Total: 2 cycles from accept to rspValid. Writes produce no response.
- Response buffer is a 2-entry FIFO, in order.
  - Capture and pop in the same cycle: count unchanged, order preserved.
  - rspData holds its last value when rspValid=0.
- Fill:
  - fillStart while in IDLE moves to FILL at the next edge. It has priority over a same-cycle request, which is not accepted.
  - fillStart outside IDLE is ignored.
  - In FILL: ramEnable=1, ramWriteEnable=all ones, ramAddress=counter, ramDataIn=FILL_VAL.
  - The counter increments each cycle. At address 2^ADDR_WIDTH-1 it goes to DONE and the counter wraps to 0.
  - fillBusy=1 in FILL and DONE.
  - Total: 2^ADDR_WIDTH write cycles + 1 DONE cycle.
  - Pending/in-flight responses still drain during a fill; no new requests are accepted.
- Reset mid-operation:
  - An in-flight read or buffered data is discarded.
  - A fill aborts; words already written stay written, the rest are untouched. No fillDone is issued.

Test Plan:
(ADDR_WIDTH=4, DATA_BYTES=2, PARITY_BITS=0)
1. Write 0xBEEF to address 3 (byteEnable=2'b11), then read address 3 with rspReady=1 -> rspValid rises 2 cycles after read accept; rspData=0xBEEF; exactly one response.
2. Write 0x1234 to address 3 with byteEnable=2'b10, then read address 3 -> rspData=0x12EF.
3. rspReady=0; issue back-to-back reads of addresses 1,2,3 (preloaded 0x0001/0x0002/0x0003) -> reqReady drops after 2 accepts. Raise rspReady -> responses 0x0001, 0x0002; the third read is accepted after the first pop; 0x0003 is returned last.
4. FILL_VAL=0xA5A5; pulse fillStart in IDLE -> fillBusy high for 17 cycles; 16 consecutive writes to addresses 0..15; fillDone pulses once in cycle 17; reqReady=0 throughout. Readback of addresses 0 and 15 = 0xA5A5.
5. Preload address 10 with 0x5555; start fill; assert resetN low when ramAddress=7 -> all outputs reset immediately (asynchronously) and no fillDone. After release, address 10 reads 0x5555 and address 6 reads 0xA5A5.
6. fillStart and reqValid (write 0x1111 to address 2) in the same cycle -> request not accepted; after fillDone, the request is accepted; readback of address 2 = 0x1111.
